// File: rtl/pattern_sequencer.sv
// rtl/pattern_sequencer.sv - record-and-playback LED pattern sequencer
// Define PATTERN_SEQ_LOOP_EN to repeat playback endlessly instead of stopping at the end.
module pattern_sequencer #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4,
  parameter int DIV   = 6,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int TW = (DIV > 1) ? $clog2(DIV) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rec_en,
  input  logic             wr_strobe,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             start,
  input  logic             stop,
  output logic [WIDTH-1:0] led,
  output logic [AW-1:0]    step,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RECORD = 2'd1,
    PLAY   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] led_q, led_d;
  logic [AW-1:0]    step_q, step_d;
  logic [AW:0]      len_q, len_d;
  logic [TW-1:0]    tick_q, tick_d;
  logic             done_q, done_d;
  logic             busy_q;
  logic             rec_hold_q, rec_hold_d;

  logic [WIDTH-1:0] mem [DEPTH];
  logic             mem_we;
  logic [AW-1:0]    step_inc;
  logic             last_step;
  logic             tick_exp;

  assign step_inc  = step_q + 1'b1;
  assign last_step = ({1'b0, step_q} == (len_q - 1'b1));
  assign tick_exp  = (tick_q == TW'(DIV - 1));

  always_comb begin
    state_d    = state_q;
    led_d      = led_q;
    step_d     = step_q;
    len_d      = len_q;
    tick_d     = tick_q;
    done_d     = 1'b0;
    mem_we     = 1'b0;
    rec_hold_d = rec_hold_q;
    // A full record leaves rec_en high; hold off re-entry until it is released.
    if (!rec_en) rec_hold_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (rec_en && !rec_hold_q) begin
          state_d = RECORD;
          step_d  = '0;
          len_d   = '0;
        end else if (start && (len_q != '0)) begin
          state_d = PLAY;
          step_d  = '0;
          led_d   = mem[0];
          tick_d  = '0;
        end
      end

      RECORD: begin
        if (wr_strobe) begin
          mem_we = 1'b1;
          led_d  = wr_data;
          step_d = step_inc;
          len_d  = len_q + 1'b1;
        end
        if (wr_strobe && (step_q == AW'(DEPTH - 1))) begin
          state_d    = IDLE;
          step_d     = '0;
          rec_hold_d = rec_en;
        end else if (!rec_en) begin
          state_d = IDLE;
          step_d  = '0;
        end
      end

      PLAY: begin
        if (stop) begin
          state_d = IDLE;
          step_d  = '0;
          tick_d  = '0;
        end else if (tick_exp) begin
          tick_d = '0;
          if (last_step) begin
            step_d = '0;
            done_d = 1'b1;
`ifdef PATTERN_SEQ_LOOP_EN
            led_d  = mem[0];
`else
            state_d = IDLE;
`endif
          end else begin
            step_d = step_inc;
            led_d  = mem[step_inc];
          end
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      led_q      <= '0;
      step_q     <= '0;
      len_q      <= '0;
      tick_q     <= '0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      rec_hold_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      led_q      <= led_d;
      step_q     <= step_d;
      len_q      <= len_d;
      tick_q     <= tick_d;
      done_q     <= done_d;
      busy_q     <= (state_d != IDLE);
      rec_hold_q <= rec_hold_d;
    end
  end

  // Pattern storage survives reset; length=0 keeps stale contents hidden.
  always_ff @(posedge clk) begin
    if (mem_we) mem[step_q] <= wr_data;
  end

  assign led  = led_q;
  assign step = step_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_pattern_sequencer.sv
// tb/tb_pattern_sequencer.sv - randomized self-checking bench for pattern_sequencer
module tb_pattern_sequencer;
  localparam int WIDTH = 2;
  localparam int DEPTH = 4;
  localparam int DIV   = 6;
  localparam int AW    = $clog2(DEPTH);

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             rec_en = 1'b0;
  logic             wr_strobe = 1'b0;
  logic [WIDTH-1:0] wr_data = '0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic [WIDTH-1:0] led;
  logic [AW-1:0]    step;
  logic             busy;
  logic             done;

  int n_cmp = 0;
  int n_fail = 0;

  logic [WIDTH-1:0] m_mem [DEPTH];
  int               m_len = 0;
  logic [WIDTH-1:0] pat [8];

  pattern_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DIV(DIV)) dut (
    .clk(clk), .reset(reset), .rec_en(rec_en), .wr_strobe(wr_strobe),
    .wr_data(wr_data), .start(start), .stop(stop),
    .led(led), .step(step), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic clk_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic record_pattern(input int n, input bit merge);
    rec_en = 1'b1;
    clk_cycle();
    for (int k = 0; k < n; k++) begin
      wr_strobe = 1'b1;
      wr_data   = pat[k];
      if (merge && k == n - 1) rec_en = 1'b0;
      clk_cycle();
      wr_strobe = 1'b0;
      if (k != n - 1) repeat ($urandom_range(0, 2)) clk_cycle();
    end
    rec_en = 1'b0;
    clk_cycle();
    m_len = (n < DEPTH) ? n : DEPTH;
    for (int k = 0; k < m_len; k++) m_mem[k] = pat[k];
  endtask

  task automatic run_playback(input string tag);
    logic [WIDTH-1:0] exp_q [$];
    for (int s = 0; s < m_len; s++)
      for (int c = 0; c < DIV; c++) exp_q.push_back(m_mem[s]);
    start = 1'b1;
    for (int i = 0; i < exp_q.size(); i++) begin
      clk_cycle();
      start = 1'b0;
      n_cmp++;
      if ({led, step, busy, done} !== {exp_q[i], AW'(i / DIV), 1'b1, 1'b0}) begin
        n_fail++;
        $display("FAIL %s play[%0d]: got led=%h step=%0d busy=%b done=%b, expected led=%h step=%0d busy=1 done=0",
                 tag, i, led, step, busy, done, exp_q[i], i / DIV);
      end
    end
    clk_cycle();
    n_cmp++;
`ifdef PATTERN_SEQ_LOOP_EN
    if ({led, step, busy, done} !== {m_mem[0], AW'(0), 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL %s wrap: got led=%h step=%0d busy=%b done=%b, expected led=%h step=0 busy=1 done=1",
               tag, led, step, busy, done, m_mem[0]);
    end
`else
    if ({led, step, busy, done} !== {m_mem[m_len-1], AW'(0), 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL %s end: got led=%h step=%0d busy=%b done=%b, expected led=%h step=0 busy=0 done=1",
               tag, led, step, busy, done, m_mem[m_len-1]);
    end
`endif
    clk_cycle();
    n_cmp++;
`ifdef PATTERN_SEQ_LOOP_EN
    if ({led, busy, done} !== {m_mem[0], 1'b1, 1'b0}) begin
`else
    if ({led, busy, done} !== {m_mem[m_len-1], 1'b0, 1'b0}) begin
`endif
      n_fail++;
      $display("FAIL %s after_end: got led=%h busy=%b done=%b", tag, led, busy, done);
    end
    stop = 1'b1;
    clk_cycle();
    stop = 1'b0;
    clk_cycle();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #3;
    n_cmp++;
    if ({led, step, busy, done} !== {WIDTH'(0), AW'(0), 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state: got led=%h step=%0d busy=%b done=%b, expected all 0", led, step, busy, done);
    end
    clk_cycle();
    reset = 1'b0;
    m_len = 0;
    clk_cycle();
  endtask

  task automatic test_record();
    pat[0] = WIDTH'(1); pat[1] = WIDTH'(2); pat[2] = WIDTH'(3);
    rec_en = 1'b1;
    clk_cycle();
    n_cmp++;
    if ({step, busy} !== {AW'(0), 1'b1}) begin
      n_fail++;
      $display("FAIL record_enter: got step=%0d busy=%b, expected step=0 busy=1", step, busy);
    end
    for (int k = 0; k < 3; k++) begin
      wr_strobe = 1'b1;
      wr_data   = pat[k];
      clk_cycle();
      wr_strobe = 1'b0;
      n_cmp++;
      if ({led, step, busy} !== {pat[k], AW'(k + 1), 1'b1}) begin
        n_fail++;
        $display("FAIL record_write[%0d]: got led=%h step=%0d busy=%b, expected led=%h step=%0d busy=1",
                 k, led, step, busy, pat[k], k + 1);
      end
    end
    rec_en = 1'b0;
    clk_cycle();
    n_cmp++;
    if ({led, step, busy} !== {WIDTH'(3), AW'(0), 1'b0}) begin
      n_fail++;
      $display("FAIL record_exit: got led=%h step=%0d busy=%b, expected led=3 step=0 busy=0", led, step, busy);
    end
    m_len = 3;
    for (int k = 0; k < 3; k++) m_mem[k] = pat[k];
    run_playback("record");
  endtask

  task automatic test_full_record();
    pat[0] = WIDTH'(0); pat[1] = WIDTH'(1); pat[2] = WIDTH'(2);
    pat[3] = WIDTH'(3); pat[4] = WIDTH'(1);
    rec_en = 1'b1;
    clk_cycle();
    for (int k = 0; k < 5; k++) begin
      wr_strobe = 1'b1;
      wr_data   = pat[k];
      clk_cycle();
      wr_strobe = 1'b0;
      n_cmp++;
      if (k < DEPTH - 1) begin
        if ({led, step, busy} !== {pat[k], AW'(k + 1), 1'b1}) begin
          n_fail++;
          $display("FAIL full_write[%0d]: got led=%h step=%0d busy=%b", k, led, step, busy);
        end
      end else if ({led, step, busy} !== {pat[DEPTH-1], AW'(0), 1'b0}) begin
        n_fail++;
        $display("FAIL full_stop[%0d]: got led=%h step=%0d busy=%b, expected led=%h step=0 busy=0",
                 k, led, step, busy, pat[DEPTH-1]);
      end
    end
    rec_en = 1'b0;
    clk_cycle();
    m_len = DEPTH;
    for (int k = 0; k < DEPTH; k++) m_mem[k] = pat[k];
    run_playback("full");
  endtask

  task automatic test_empty_start();
    reset = 1'b1;
    clk_cycle();
    reset = 1'b0;
    m_len = 0;
    start = 1'b1;
    clk_cycle();
    start = 1'b0;
    n_cmp++;
    if ({led, busy} !== {WIDTH'(0), 1'b0}) begin
      n_fail++;
      $display("FAIL empty_start: got led=%h busy=%b, expected led=0 busy=0", led, busy);
    end
    start  = 1'b1;
    rec_en = 1'b1;
    clk_cycle();
    start  = 1'b0;
    rec_en = 1'b0;
    n_cmp++;
    if ({step, busy} !== {AW'(0), 1'b1}) begin
      n_fail++;
      $display("FAIL start_and_rec: got step=%0d busy=%b, expected step=0 busy=1", step, busy);
    end
    clk_cycle();
    start = 1'b1;
    clk_cycle();
    start = 1'b0;
    n_cmp++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL empty_record_start: got busy=%b, expected 0", busy);
    end
  endtask

  task automatic test_stop();
    for (int it = 0; it < 4; it++) begin
      int n;
      int k;
      n = $urandom_range(2, DEPTH);
      for (int j = 0; j < n; j++) pat[j] = WIDTH'($urandom);
      record_pattern(n, 1'b0);
      k = (it == 0) ? m_len - 1 : $urandom_range(0, m_len - 1);
      start = 1'b1;
      for (int c = 0; c < (k + 1) * DIV; c++) begin
        clk_cycle();
        start = 1'b0;
      end
      stop = 1'b1;
      clk_cycle();
      stop = 1'b0;
      n_cmp++;
      if ({led, step, busy, done} !== {m_mem[k], AW'(0), 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL stop_at_expiry[%0d]: got led=%h step=%0d busy=%b done=%b, expected led=%h step=0 busy=0 done=0",
                 k, led, step, busy, done, m_mem[k]);
      end
      clk_cycle();
      n_cmp++;
      if ({led, busy, done} !== {m_mem[k], 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL stop_hold[%0d]: got led=%h busy=%b done=%b", k, led, busy, done);
      end
    end
  endtask

  task automatic test_reset_mid_play();
    for (int j = 0; j < 3; j++) pat[j] = WIDTH'($urandom_range(1, 3));
    record_pattern(3, 1'b0);
    start = 1'b1;
    clk_cycle();
    start = 1'b0;
    repeat ($urandom_range(1, DIV * 3 - 2)) clk_cycle();
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if ({led, step, busy, done} !== {WIDTH'(0), AW'(0), 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_mid_play: got led=%h step=%0d busy=%b done=%b, expected all 0", led, step, busy, done);
    end
    #2 reset = 1'b0;
    m_len = 0;
    clk_cycle();
    start = 1'b1;
    clk_cycle();
    start = 1'b0;
    n_cmp++;
    if ({led, step, busy} !== {WIDTH'(0), AW'(0), 1'b0}) begin
      n_fail++;
      $display("FAIL start_after_reset: got led=%h step=%0d busy=%b, expected 0", led, step, busy);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      int n;
      n = $urandom_range(0, 6);
      for (int j = 0; j < n; j++) pat[j] = WIDTH'($urandom);
      record_pattern(n, 1'($urandom_range(0, 1)));
      if (m_len == 0) begin
        start = 1'b1;
        clk_cycle();
        start = 1'b0;
        n_cmp++;
        if (busy !== 1'b0) begin
          n_fail++;
          $display("FAIL random_empty[%0d]: got busy=%b, expected 0", it, busy);
        end
      end else begin
        run_playback($sformatf("random%0d", it));
      end
    end
  endtask

  initial begin
    test_reset();
    test_record();
    test_full_record();
    test_empty_start();
    test_stop();
    test_reset_mid_play();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pattern_sequencer.md
PATTERN_SEQUENCER -- requirements
Module: pattern_sequencer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 2, meaning bits per pattern step.
REQ-002 The block SHALL have parameter DEPTH, default 4, meaning the number of pattern steps stored (>=2); AW = clog2(DEPTH).
REQ-003 The block SHALL have parameter DIV, default 6, meaning clk cycles per playback step (>=1).
REQ-004 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-006 The block SHALL have port rec_en, input, 1, a level that requests record mode.
REQ-007 The block SHALL have port wr_strobe, input, 1, a single-cycle, pre-debounced write pulse.
REQ-008 The block SHALL have port wr_data, input, WIDTH, the pattern value to record.
REQ-009 The block SHALL have port start, input, 1, a pulse that starts playback.
REQ-010 The block SHALL have port stop, input, 1, a pulse that aborts playback.
REQ-011 The block SHALL have port led, output, WIDTH, the current displayed pattern.
REQ-012 The block SHALL have port step, output, AW, the current play or write pointer.
REQ-013 The block SHALL have port busy, output, 1, high whenever state is not IDLE.
REQ-014 The block SHALL have port done, output, 1, a one-cycle pulse at end of playback.

Function
REQ-015 The FSM SHALL have the states IDLE, RECORD and PLAY; all outputs SHALL be registered.
REQ-016 In IDLE with rec_en=1, the block SHALL enter RECORD next cycle with step=0; rec_en SHALL win over a simultaneous start.
REQ-017 In IDLE with start=1, rec_en=0 and length>0, the block SHALL enter PLAY next cycle: step=0, led=mem[0], tick counter=0.
REQ-018 A start in IDLE with length=0 SHALL be ignored.
REQ-019 In RECORD, each wr_strobe SHALL write wr_data to mem[step], set led=wr_data, and increment step and length, all visible the next cycle.
REQ-020 In RECORD, after the write to step DEPTH-1 the block SHALL return to IDLE with length=DEPTH and step=0; further strobes SHALL be ignored.
REQ-021 In RECORD, rec_en=0 SHALL return the block to IDLE next cycle with length equal to the number of writes, 0 allowed; wr_strobe in that same cycle SHALL still be written.
REQ-022 In PLAY, each step SHALL be held exactly DIV cycles; on the DIV-th cycle step SHALL advance and led SHALL become mem[step+1].
REQ-023 In PLAY, when the tick expires at step=length-1, end-of-pattern handling per REQ-029/REQ-030 SHALL apply.
REQ-024 stop in PLAY SHALL force IDLE next cycle with led held, done=0 and step=0; stop SHALL have priority over tick expiry.
REQ-025 wr_strobe outside RECORD, and start or rec_en in PLAY or RECORD (beyond REQ-021), SHALL be ignored.
REQ-026 step and length arithmetic SHALL wrap or saturate only as stated; length SHALL range 0..DEPTH and be AW+1 bits wide.

Reset
REQ-027 Asserting reset SHALL immediately force: state IDLE, led=0, step=0, length=0, busy=0, done=0, tick counter=0, including mid-RECORD and mid-PLAY.
REQ-028 Memory contents SHALL NOT be cleared by reset, and SHALL be unobservable until rewritten because length=0.

Configuration
REQ-029 With macro PATTERN_SEQ_LOOP_EN defined, the end of pattern SHALL wrap step to 0 with led=mem[0], stay in PLAY, and pulse done for one cycle on each wrap.
REQ-030 Without PATTERN_SEQ_LOOP_EN, the end of pattern SHALL move to IDLE with led holding mem[length-1], step=0, busy=0, and done pulsed one cycle.

Verification
REQ-031 Record test: rec_en=1, strobes with 01, 10, 11, then rec_en=0 SHALL give length=3 and led=11; after start, led SHALL read 01, 10, 11 for 6 cycles each, then done=1 for one cycle.
REQ-032 Loop test (PATTERN_SEQ_LOOP_EN): the same pattern SHALL give led 01 again on cycle 19 after PLAY entry, with busy remaining 1.
REQ-033 Full-record test: 5 strobes with 00, 01, 10, 11, 01 SHALL return to IDLE after the 4th strobe; the 5th SHALL be ignored; playback SHALL show 00, 01, 10, 11.
REQ-034 Empty-start test: start after reset with length=0 SHALL leave busy=0 and led=0; start and rec_en together in IDLE SHALL enter RECORD.
REQ-035 Stop test: stop on the same cycle as tick expiry in PLAY SHALL give IDLE with led unchanged and done=0.
REQ-036 Reset test: reset asserted mid-PLAY, between clk edges, SHALL give led=0, busy=0 and step=0 before the next edge; a subsequent start SHALL be ignored.
